// File: rtl/block_retirer.sv
// block_retirer: folds the per-instruction commit stream into E-Trace
// instruction blocks {iaddr, iretire, itype, ilastsize}. Each block closes
// on a non-zero itype, on an exception/interrupt event, or when the
// halfword counter saturates.
// Build option: BLOCK_RETIRER_SKID_EN selects a 2-entry output FIFO instead
// of the single output register.
// XLEN/ITYPE_LEN defaults mirror connector_pkg (64-bit, 3-bit itype).
module block_retirer #(
    parameter int XLEN        = 64,
    parameter int ITYPE_LEN   = 3,
    parameter int IRETIRE_LEN = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   compressed_i,
    output logic                   block_valid_o,
    input  logic                   block_ready_i,
    output logic [XLEN-1:0]        iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic                   ilastsize_o,
    output logic                   overflow_o
);

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic [ITYPE_LEN-1:0]   itype;
        logic                   ilastsize;
    } blk_t;

    // Close threshold 2^N-2: leaves room for one more +2 without wrapping.
    localparam logic [IRETIRE_LEN-1:0] SAT_LIMIT = {{(IRETIRE_LEN-1){1'b1}}, 1'b0};

    logic                   open_q, open_d;
    logic [XLEN-1:0]        start_q, start_d;
    logic [IRETIRE_LEN-1:0] count_q, count_d;
    logic                   last_q, last_d;
    logic [IRETIRE_LEN-1:0] inc, cnt_post;
    logic                   exc_evt;
    logic                   push;
    blk_t                   blk_new;
    blk_t                   head;
    logic                   ovf_q;

    // Accumulator next state and block-close decision
    always_comb begin
        inc      = compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
        cnt_post = (open_q ? count_q : '0) + inc;
        exc_evt  = !valid_i && (itype_i == ITYPE_LEN'(1) || itype_i == ITYPE_LEN'(2));
        open_d   = open_q;
        start_d  = start_q;
        count_d  = count_q;
        last_d   = last_q;
        push     = 1'b0;
        blk_new  = '0;
        if (valid_i) begin
            start_d = open_q ? start_q : pc_i;
            count_d = cnt_post;
            last_d  = !compressed_i;
            open_d  = 1'b1;
            if (itype_i != '0 || cnt_post >= SAT_LIMIT) begin
                push              = 1'b1;
                blk_new.iaddr     = start_d;
                blk_new.iretire   = cnt_post;
                blk_new.itype     = itype_i;
                blk_new.ilastsize = !compressed_i;
            end
        end else if (exc_evt) begin
            // An event with nothing open still emits an empty block at pc_i
            push              = 1'b1;
            blk_new.iaddr     = open_q ? start_q : pc_i;
            blk_new.iretire   = open_q ? count_q : '0;
            blk_new.itype     = itype_i;
            blk_new.ilastsize = open_q ? last_q : 1'b0;
        end
        if (push) begin
            open_d  = 1'b0;
            count_d = '0;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q  <= 1'b0;
            start_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            open_q  <= open_d;
            start_q <= start_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

`ifdef BLOCK_RETIRER_SKID_EN
    blk_t [1:0] fifo_q;
    logic       rd_q, wr_q;
    logic [1:0] cnt_q;
    logic       pop, accept;

    assign pop    = (cnt_q != 2'd0) && block_ready_i;
    assign accept = push && ((cnt_q != 2'd2) || pop);

    // Two-entry in-order FIFO; a pop frees a slot for a push in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            cnt_q  <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                fifo_q[wr_q] <= blk_new;
                wr_q         <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, accept} - {1'b0, pop};
            if (push && !accept) ovf_q <= 1'b1;
        end
    end

    assign head          = fifo_q[rd_q];
    assign block_valid_o = (cnt_q != 2'd0);
`else
    blk_t out_q;
    logic full_q;

    // Single output register; reloads in the cycle it drains (no bubble)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push && (!full_q || block_ready_i)) begin
                out_q  <= blk_new;
                full_q <= 1'b1;
            end else if (full_q && block_ready_i) begin
                full_q <= 1'b0;
            end
            if (push && full_q && !block_ready_i) ovf_q <= 1'b1;
        end
    end

    assign head          = out_q;
    assign block_valid_o = full_q;
`endif

    assign iaddr_o     = head.iaddr;
    assign iretire_o   = head.iretire;
    assign itype_o     = head.itype;
    assign ilastsize_o = head.ilastsize;
    assign overflow_o  = ovf_q;

endmodule

// File: doc/block_retirer.md
# block_retirer

Compresses the per-instruction commit stream into E-Trace instruction blocks, one block per discontinuity. Sits directly downstream of the instruction-type detector in the CVA6 trace-encoder connector and consumes its `itype` output. It accumulates retired halfwords from the first PC of a run until a non-zero itype or counter saturation closes the block. Each closed block is presented to the encoder-side packet stage over a valid/ready handshake.

## Interface
- `XLEN`, default `connector_pkg::XLEN`: address width.
- `ITYPE_LEN`, default `connector_pkg::ITYPE_LEN`: itype width (3 or 4).
- `IRETIRE_LEN`, default 32: iretire counter width, in 16-bit units.
- `clk_i` in, 1: single clock.
- `rst_ni` in, 1: asynchronous, active-low reset.
- `valid_i` in, 1: one instruction committed this cycle.
- `itype_i` in, ITYPE_LEN: itype of the committed instruction, or of an event when `valid_i`=0.
- `pc_i` in, XLEN: PC of the committed instruction.
- `compressed_i` in, 1: committed instruction is 16-bit.
- `block_valid_o` out, 1: block held at the output.
- `block_ready_i` in, 1: downstream accepts the block.
- `iaddr_o` out, XLEN: PC of the first instruction in the block.
- `iretire_o` out, IRETIRE_LEN: halfwords retired in the block.
- `itype_o` out, ITYPE_LEN: itype that closed the block; 0 means saturation.
- `ilastsize_o` out, 1: size of the last instruction; 0 = 2 bytes, 1 = 4 bytes.
- `overflow_o` out, 1: sticky flag, set when a closed block was dropped.

## Operation
- Accumulator state:
  - `open` flag
  - `start_addr`
  - `count` (IRETIRE_LEN bits)
  - `last_size`
- Retire with `valid_i`=1:
  - If `!open`: `start_addr`←`pc_i`, `count`←inc, `open`←1.
  - Else: `count`←`count`+inc.
  - inc = 1 if `compressed_i`, else 2. `last_size`←`!compressed_i`.
- Close conditions, evaluated on the post-increment value:
  - Retire with `itype_i`≠0: the block includes this instruction and carries `itype_i`.
  - Retire with itype 0 and post-increment `count` ≥ 2^IRETIRE_LEN−2: block carries itype 0.
  - `valid_i`=0 and `itype_i`∈{1,2} (exception/interrupt): the block carries `itype_i`. If `!open`, emit `iretire`=0, `iaddr`=`pc_i`, `ilastsize`=0.
  - `valid_i`=0 with any other itype: ignored.
- On close: push {start_addr, count, itype, last_size} to the output stage. Accumulator returns to `!open`, `count`=0.
- Output stage: a single register.
  - Load when empty, or when full and `block_ready_i`=1 in the same cycle (no bubble).
  - A push while full and not ready drops the new block and sets `overflow_o`. The held block is unchanged.
  - The accumulator still resets on a dropped close.
- Counter arithmetic is unsigned and never wraps; saturation close guarantees headroom for the next +2.

## Timing
- Reset: all outputs 0, `open`=0, accumulator 0, output register empty.
- Latency: a close in cycle N gives `block_valid_o`=1 in cycle N+1 with registered fields. Outputs are never combinational from inputs.
- Handshake:
  - Transfer happens when `block_valid_o` and `block_ready_i` are both 1.
  - Fields stay stable while valid and not ready.
  - `block_valid_o` deasserts the cycle after a transfer unless a new block is loaded.
- Back-to-back closes on consecutive cycles with `block_ready_i`=1 give a 1 block/cycle throughput.
- `overflow_o` clears only on reset.
- Reset mid-block: the partial block is discarded and no block is emitted.

## Configuration
- `BLOCK_RETIRER_SKID_EN`
  - Defined: the output stage is a 2-entry FIFO in order. A drop occurs only when both entries are full and not ready. `block_valid_o` = FIFO non-empty.
  - Undefined: single output register as described under Operation.

## Test plan
- Simple block: retire pc 0x80000000 (4B, itype 0), then 0x80000004 (2B, itype 0), then 0x80000006 (4B, itype 5); ready=1.
  - One cycle after the third retire: `iaddr_o`=0x80000000, `iretire_o`=5, `itype_o`=5, `ilastsize_o`=1.
- Interrupt with nothing open: `valid_i`=0, `itype_i`=2, `pc_i`=0x1000.
  - Next cycle: block {0x1000, 0, 2, 0}.
- Saturation with IRETIRE_LEN=4: retire 4B instructions with itype 0 from pc 0x100.
  - After the 7th retire (`count`=14): block {0x100, 14, 0, 1}.
  - The 8th instruction starts a new block at 0x11C.
- Backpressure, skid off: hold `block_ready_i`=0 and close two blocks.
  - First block held stable, second block dropped, `overflow_o`=1.
  - Release ready: the first block transfers and `overflow_o` stays 1.
- Backpressure, skid on: same stimulus.
  - Both blocks delivered in order and `overflow_o`=0.
  - A third close while full sets `overflow_o`=1.
- Reset mid-block: retire 3 instructions with itype 0, assert `rst_ni`=0 for 1 cycle.
  - All outputs 0, no block emitted.
  - The next retire at 0x2000 starts a block with `iaddr`=0x2000.
